// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor; master drives start and operands,
// slave returns status and the latched difference, borrow and overflow.
interface serial_sub_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] D;
  logic         Bout;
  logic         V;

  modport master (output start, A, B, input busy, done, D, Bout, V);
  modport slave  (input start, A, B, output busy, done, D, Bout, V);
endinterface

// File: rtl/serial_sub.sv
// Bit-serial D = A - B, LSB first; done pulses N+1 cycles after an accepted start.
// start is ignored while busy; results hold from DONE until the next accepted start.
module serial_sub #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);
  localparam int             CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  d_r;
  logic [CW-1:0] cnt;
  logic          bw;
  logic          bout_r;
  logic          v_r;
  logic          a_msb;
  logic          b_msb;
  logic          busy_c;
  logic          done_c;
  logic          a_bit;
  logic          b_bit;
  logic          d_bit;
  logic          bw_nxt;
  logic          last_bit;

  assign a_bit    = a_sh[0];
  assign b_bit    = b_sh[0];
  assign d_bit    = a_bit ^ b_bit ^ bw;
  assign bw_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw);
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_r    <= '0;
      cnt    <= '0;
      bw     <= 1'b0;
      bout_r <= 1'b0;
      v_r    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_sh  <= bus.A;
          b_sh  <= bus.B;
          a_msb <= bus.A[N-1];
          b_msb <= bus.B[N-1];
          bw    <= 1'b0;
          cnt   <= '0;
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_r  <= {d_bit, d_r[N-1:1]};
          bw   <= bw_nxt;
          // d_bit on the last edge is the result MSB, so overflow is known right here
          if (last_bit) begin
            bout_r <= bw_nxt;
            v_r    <= (a_msb != b_msb) && (d_bit != a_msb);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.D    = d_r;
  assign bus.Bout = bout_r;
  assign bus.V    = v_r;
endmodule
